// File: rtl/peripheral_mpram_axi4_pkg.sv
// Shared AXI4 encodings and bridge FSM states for the MPRAM AXI4 initiator.
package peripheral_mpram_axi4_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW_W,
      ST_B
   } state_t;

endpackage

// File: rtl/peripheral_mpram_axi4_initiator.sv
// Memory-port to AXI4 bridge: one single-beat read or write outstanding at a time.
module peripheral_mpram_axi4_initiator
   import peripheral_mpram_axi4_pkg::*;
#(
   parameter int unsigned             AXI_ID_WIDTH   = 10,
   parameter int unsigned             AXI_ADDR_WIDTH = 64,
   parameter int unsigned             AXI_DATA_WIDTH = 64,
   parameter int unsigned             AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int unsigned             AXI_USER_WIDTH = 10,
   parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
   input  logic [AXI_STRB_WIDTH-1:0] be_i,
   input  logic [AXI_DATA_WIDTH-1:0] data_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [AXI_DATA_WIDTH-1:0] data_o,
   output logic                      err_o,
   output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
   output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
   output logic [7:0]                axi_aw_len,
   output logic [2:0]                axi_aw_size,
   output logic [1:0]                axi_aw_burst,
   output logic                      axi_aw_lock,
   output logic [3:0]                axi_aw_cache,
   output logic [2:0]                axi_aw_prot,
   output logic [3:0]                axi_aw_qos,
   output logic [3:0]                axi_aw_region,
   output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
   output logic                      axi_aw_valid,
   input  logic                      axi_aw_ready,
   output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
   output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
   output logic                      axi_w_last,
   output logic [AXI_USER_WIDTH-1:0] axi_w_user,
   output logic                      axi_w_valid,
   input  logic                      axi_w_ready,
   input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
   input  logic [1:0]                axi_b_resp,
   input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
   input  logic                      axi_b_valid,
   output logic                      axi_b_ready,
   output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
   output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
   output logic [7:0]                axi_ar_len,
   output logic [2:0]                axi_ar_size,
   output logic [1:0]                axi_ar_burst,
   output logic                      axi_ar_lock,
   output logic [3:0]                axi_ar_cache,
   output logic [2:0]                axi_ar_prot,
   output logic [3:0]                axi_ar_qos,
   output logic [3:0]                axi_ar_region,
   output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
   output logic                      axi_ar_valid,
   input  logic                      axi_ar_ready,
   input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
   input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
   input  logic [1:0]                axi_r_resp,
   input  logic                      axi_r_last,
   input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
   input  logic                      axi_r_valid,
   output logic                      axi_r_ready
);

   localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_STRB_WIDTH));

   state_t                    state;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_STRB_WIDTH-1:0] be_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q;
   logic                      aw_done;
   logic                      w_done;
   logic                      aw_hs;
   logic                      w_hs;
   logic                      r_hs;
   logic                      b_hs;
   logic                      unused_inputs;

   // Valids decode from registered state only, so none of them depends on a ready.
   assign axi_ar_valid = (state == ST_AR);
   assign axi_r_ready  = (state == ST_R);
   assign axi_aw_valid = (state == ST_AW_W) && !aw_done;
   assign axi_w_valid  = (state == ST_AW_W) && !w_done;
   assign axi_b_ready  = (state == ST_B);

   assign aw_hs = axi_aw_valid && axi_aw_ready;
   assign w_hs  = axi_w_valid && axi_w_ready;
   assign r_hs  = axi_r_ready && axi_r_valid;
   assign b_hs  = axi_b_ready && axi_b_valid;

   assign gnt_o    = (state == ST_IDLE) && req_i;
   assign rvalid_o = r_hs || b_hs;
   assign data_o   = r_hs ? axi_r_data : rdata_q;
   assign err_o    = (r_hs && axi_r_resp[1]) || (b_hs && axi_b_resp[1]);

   assign axi_aw_id     = AXI_ID;
   assign axi_aw_addr   = addr_q;
   assign axi_aw_len    = '0;
   assign axi_aw_size   = AXI_SIZE;
   assign axi_aw_burst  = BURST_INCR;
   assign axi_aw_lock   = 1'b0;
   assign axi_aw_cache  = '0;
   assign axi_aw_prot   = '0;
   assign axi_aw_qos    = '0;
   assign axi_aw_region = '0;
   assign axi_aw_user   = '0;

   assign axi_w_data = wdata_q;
   assign axi_w_strb = be_q;
   assign axi_w_last = 1'b1;
   assign axi_w_user = '0;

   assign axi_ar_id     = AXI_ID;
   assign axi_ar_addr   = addr_q;
   assign axi_ar_len    = '0;
   assign axi_ar_size   = AXI_SIZE;
   assign axi_ar_burst  = BURST_INCR;
   assign axi_ar_lock   = 1'b0;
   assign axi_ar_cache  = '0;
   assign axi_ar_prot   = '0;
   assign axi_ar_qos    = '0;
   assign axi_ar_region = '0;
   assign axi_ar_user   = '0;

   assign unused_inputs = ^{axi_b_id, axi_b_user, axi_b_resp[0], axi_r_id,
                            axi_r_user, axi_r_resp[0], axi_r_last};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_i) begin
                  addr_q  <= addr_i;
                  be_q    <= be_i;
                  wdata_q <= data_i;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= we_i ? ST_AW_W : ST_AR;
               end
            end
            ST_AR: if (axi_ar_ready) state <= ST_R;
            ST_R: begin
               if (axi_r_valid) begin
                  rdata_q <= axi_r_data;
                  state   <= ST_IDLE;
               end
            end
            ST_AW_W: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs) w_done <= 1'b1;
               // AW and W may complete in either order or together.
               if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_B;
            end
            ST_B: if (axi_b_valid) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_mpram_axi4_initiator.sv
// Directed bench for the MPRAM AXI4 initiator with queue-based response scoreboard.
module tb_peripheral_mpram_axi4_initiator;
   import peripheral_mpram_axi4_pkg::*;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } resp_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
   } wbeat_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0, we_i = 1'b0;
   logic [63:0] addr_i = '0;
   logic [7:0]  be_i = '0;
   logic [63:0] data_i = '0;
   logic        gnt_o, rvalid_o, err_o;
   logic [63:0] data_o;

   logic [9:0]  axi_aw_id, axi_ar_id;
   logic [63:0] axi_aw_addr, axi_ar_addr;
   logic [7:0]  axi_aw_len, axi_ar_len;
   logic [2:0]  axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
   logic [1:0]  axi_aw_burst, axi_ar_burst;
   logic        axi_aw_lock, axi_ar_lock;
   logic [3:0]  axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos, axi_aw_region, axi_ar_region;
   logic [9:0]  axi_aw_user, axi_ar_user, axi_w_user;
   logic        axi_aw_valid, axi_ar_valid, axi_w_valid, axi_w_last, axi_b_ready, axi_r_ready;
   logic [63:0] axi_w_data;
   logic [7:0]  axi_w_strb;
   logic        axi_aw_ready = 1'b0, axi_w_ready = 1'b0, axi_ar_ready = 1'b0;
   logic        axi_b_valid = 1'b0, axi_r_valid = 1'b0, axi_r_last = 1'b1;
   logic [1:0]  axi_b_resp = '0, axi_r_resp = '0;
   logic [9:0]  axi_b_id = '0, axi_r_id = '0, axi_b_user = '0, axi_r_user = '0;
   logic [63:0] axi_r_data = '0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [63:0] last_rd = '0;

   logic [63:0] exp_ar[$];
   logic [63:0] exp_aw[$];
   wbeat_t      exp_w[$];
   resp_t       exp_resp[$];

   always #5 clk_i = ~clk_i;

   peripheral_mpram_axi4_initiator #(
      .AXI_ID_WIDTH  (10),
      .AXI_ADDR_WIDTH(64),
      .AXI_DATA_WIDTH(64),
      .AXI_STRB_WIDTH(8),
      .AXI_USER_WIDTH(10),
      .AXI_ID        (10'd0)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .be_i(be_i), .data_i(data_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .data_o(data_o),
      .err_o(err_o),
      .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
      .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock),
      .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos),
      .axi_aw_region(axi_aw_region), .axi_aw_user(axi_aw_user), .axi_aw_valid(axi_aw_valid),
      .axi_aw_ready(axi_aw_ready),
      .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
      .axi_w_user(axi_w_user), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
      .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_user(axi_b_user),
      .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
      .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
      .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock),
      .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos),
      .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user), .axi_ar_valid(axi_ar_valid),
      .axi_ar_ready(axi_ar_ready),
      .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
      .axi_r_last(axi_r_last), .axi_r_user(axi_r_user), .axi_r_valid(axi_r_valid),
      .axi_r_ready(axi_r_ready)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Fixed AR/AW fields: len, size, burst, lock, cache, prot, qos, region, id, user.
   localparam logic [48:0] FIXED_EXP = {8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 10'd0, 10'd0};

   logic        pv_ar_v, pv_ar_r, pv_aw_v, pv_aw_r, pv_w_v, pv_w_r;
   logic [63:0] pv_ar_a, pv_aw_a, pv_w_d;
   logic [7:0]  pv_w_s;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         pv_ar_v = 1'b0; pv_aw_v = 1'b0; pv_w_v = 1'b0;
         pv_ar_r = 1'b0; pv_aw_r = 1'b0; pv_w_r = 1'b0;
      end else begin
         if (axi_ar_valid && axi_ar_ready) begin
            if (exp_ar.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
            else begin
               chk("ar_addr", axi_ar_addr, exp_ar.pop_front());
               chk("ar_fixed", {axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_lock, axi_ar_cache,
                                axi_ar_prot, axi_ar_qos, axi_ar_region, axi_ar_id, axi_ar_user},
                   FIXED_EXP);
            end
         end
         if (axi_aw_valid && axi_aw_ready) begin
            if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
            else begin
               chk("aw_addr", axi_aw_addr, exp_aw.pop_front());
               chk("aw_fixed", {axi_aw_len, axi_aw_size, axi_aw_burst, axi_aw_lock, axi_aw_cache,
                                axi_aw_prot, axi_aw_qos, axi_aw_region, axi_aw_id, axi_aw_user},
                   FIXED_EXP);
            end
         end
         if (axi_w_valid && axi_w_ready) begin
            if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
            else begin
               wbeat_t wb;
               wb = exp_w.pop_front();
               chk("w_data", axi_w_data, wb.data);
               chk("w_strb_last_user", {axi_w_strb, axi_w_last, axi_w_user}, {wb.strb, 1'b1, 10'd0});
            end
         end
         if (rvalid_o) begin
            if (exp_resp.size() == 0) chk("rvalid_unexpected", 1'b1, 1'b0);
            else begin
               resp_t rs;
               rs = exp_resp.pop_front();
               chk("resp_data", data_o, rs.data);
               chk("resp_err", err_o, rs.err);
            end
         end
         // Pending valids must hold with stable payload until accepted.
         if (pv_ar_v && !pv_ar_r) chk("ar_hold", {axi_ar_valid, axi_ar_addr}, {1'b1, pv_ar_a});
         if (pv_aw_v && !pv_aw_r) chk("aw_hold", {axi_aw_valid, axi_aw_addr}, {1'b1, pv_aw_a});
         if (pv_w_v && !pv_w_r) chk("w_hold", {axi_w_valid, axi_w_strb, axi_w_data}, {1'b1, pv_w_s, pv_w_d});
         if (axi_ar_valid || axi_r_ready || axi_aw_valid || axi_w_valid || axi_b_ready)
            chk("rd_wr_overlap", (axi_ar_valid || axi_r_ready) && (axi_aw_valid || axi_w_valid || axi_b_ready), 1'b0);
         pv_ar_v = axi_ar_valid; pv_ar_r = axi_ar_ready; pv_ar_a = axi_ar_addr;
         pv_aw_v = axi_aw_valid; pv_aw_r = axi_aw_ready; pv_aw_a = axi_aw_addr;
         pv_w_v = axi_w_valid;   pv_w_r = axi_w_ready;   pv_w_d = axi_w_data; pv_w_s = axi_w_strb;
      end
   end

   // Zero-wait read: gnt at c0, AR at c1, R/rvalid at c2.
   task automatic do_read(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp);
      req_i = 1'b1; we_i = 1'b0; addr_i = a; axi_ar_ready = 1'b1; axi_r_valid = 1'b0;
      exp_ar.push_back(a);
      exp_resp.push_back('{data: d, err: resp[1]});
      last_rd = d;
      @(negedge clk_i); chk("rd_gnt_c0", gnt_o, 1'b1);
      step();
      axi_r_valid = 1'b1; axi_r_data = d; axi_r_resp = resp;
      @(negedge clk_i); chk("rd_ar_valid_c1", {axi_ar_valid, gnt_o}, 2'b10);
      step();
      req_i = 1'b0;
      @(negedge clk_i); chk("rd_rvalid_c2", rvalid_o, 1'b1);
      step();
      axi_r_valid = 1'b0; axi_ar_ready = 1'b0;
      @(negedge clk_i); chk("rd_idle_after", {rvalid_o, axi_ar_valid, axi_r_ready}, 3'b000);
      step();
   endtask

   task automatic chk_quiet(input string name);
      chk(name, {gnt_o, rvalid_o, err_o, data_o, axi_ar_valid, axi_aw_valid, axi_w_valid,
                 axi_b_ready, axi_r_ready}, '0);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      @(negedge clk_i); chk_quiet("reset_state");
      #1 rst_ni = 1'b1;
      step();
      @(negedge clk_i); chk_quiet("idle_no_req");
      step();

      do_read(64'h100, 64'hDEAD_BEEF, RESP_OKAY);
      do_read(64'h400, 64'h0BAD_F00D, RESP_SLVERR);

      // Write: AW ready at c1, W ready at c4.
      req_i = 1'b1; we_i = 1'b1; addr_i = 64'h200; data_i = 64'h1122_3344_5566_7788; be_i = 8'h0F;
      exp_aw.push_back(64'h200);
      exp_w.push_back('{data: 64'h1122_3344_5566_7788, strb: 8'h0F});
      exp_resp.push_back('{data: last_rd, err: 1'b0});
      @(negedge clk_i); chk("wr1_gnt", gnt_o, 1'b1);
      step(); req_i = 1'b0; axi_aw_ready = 1'b1;
      @(negedge clk_i); chk("wr1_c1_valids", {axi_aw_valid, axi_w_valid}, 2'b11);
      step(); axi_aw_ready = 1'b0;
      @(negedge clk_i); chk("wr1_c2_valids", {axi_aw_valid, axi_w_valid, axi_b_ready}, 3'b010);
      step();
      step(); axi_w_ready = 1'b1;
      @(negedge clk_i); chk("wr1_c4_b_ready", axi_b_ready, 1'b0);
      step(); axi_w_ready = 1'b0;
      @(negedge clk_i); chk("wr1_c5_b_ready", {axi_b_ready, axi_w_valid, rvalid_o}, 3'b100);
      step(); axi_b_valid = 1'b1; axi_b_resp = RESP_OKAY;
      @(negedge clk_i); chk("wr1_c6_rvalid", rvalid_o, 1'b1);
      step(); axi_b_valid = 1'b0;
      @(negedge clk_i); chk("wr1_done", {rvalid_o, axi_b_ready}, 2'b00);
      step();

      // Write: W accepted at c1, AW at c3, DECERR response.
      req_i = 1'b1; we_i = 1'b1; addr_i = 64'h300; data_i = 64'hA5A5_5A5A_0F0F_F0F0; be_i = 8'hFF;
      exp_aw.push_back(64'h300);
      exp_w.push_back('{data: 64'hA5A5_5A5A_0F0F_F0F0, strb: 8'hFF});
      exp_resp.push_back('{data: last_rd, err: 1'b1});
      step(); req_i = 1'b0; axi_w_ready = 1'b1;
      @(negedge clk_i); chk("wr2_c1_valids", {axi_aw_valid, axi_w_valid}, 2'b11);
      step(); axi_w_ready = 1'b0;
      @(negedge clk_i); chk("wr2_c2_valids", {axi_aw_valid, axi_w_valid}, 2'b10);
      step(); axi_aw_ready = 1'b1;
      @(negedge clk_i); chk("wr2_c3_aw_valid", axi_aw_valid, 1'b1);
      step(); axi_aw_ready = 1'b0; axi_b_valid = 1'b1; axi_b_resp = RESP_DECERR;
      @(negedge clk_i); chk("wr2_c4_b", {axi_b_ready, rvalid_o, err_o}, 3'b111);
      step(); axi_b_valid = 1'b0; axi_b_resp = RESP_OKAY;
      step();

      // Back-to-back read then write with req_i held high.
      req_i = 1'b1; we_i = 1'b0; addr_i = 64'h500; axi_ar_ready = 1'b1;
      axi_aw_ready = 1'b1; axi_w_ready = 1'b1;
      exp_ar.push_back(64'h500);
      exp_resp.push_back('{data: 64'hCAFE_F00D_1234_5678, err: 1'b0});
      last_rd = 64'hCAFE_F00D_1234_5678;
      step(); axi_r_valid = 1'b1; axi_r_data = 64'hCAFE_F00D_1234_5678; axi_r_resp = RESP_OKAY;
      step(); we_i = 1'b1; addr_i = 64'h600; data_i = 64'h0102_0304_0506_0708; be_i = 8'h3C;
      exp_aw.push_back(64'h600);
      exp_w.push_back('{data: 64'h0102_0304_0506_0708, strb: 8'h3C});
      exp_resp.push_back('{data: last_rd, err: 1'b0});
      @(negedge clk_i); chk("b2b_rvalid_nogrant", {rvalid_o, gnt_o}, 2'b10);
      step(); axi_r_valid = 1'b0;
      @(negedge clk_i); chk("b2b_second_gnt", gnt_o, 1'b1);
      step(); req_i = 1'b0; axi_b_valid = 1'b1;
      @(negedge clk_i); chk("b2b_aw_w", {axi_aw_valid, axi_w_valid}, 2'b11);
      step();
      @(negedge clk_i); chk("b2b_b_rvalid", rvalid_o, 1'b1);
      step(); axi_b_valid = 1'b0; axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_ar_ready = 1'b0;
      @(negedge clk_i); chk("b2b_idle_no_gnt", gnt_o, 1'b0);
      step();

      // Reset while AR is pending drops ar_valid asynchronously.
      req_i = 1'b1; we_i = 1'b0; addr_i = 64'h700;
      step(); req_i = 1'b0;
      @(negedge clk_i); chk("rst_ar_valid_before", axi_ar_valid, 1'b1);
      #2 rst_ni = 1'b0;
      #1 chk("rst_ar_valid_dropped", axi_ar_valid, 1'b0);
      step();
      @(negedge clk_i);
      step(); rst_ni = 1'b1;
      @(negedge clk_i); chk_quiet("post_reset_idle");
      last_rd = '0;
      step();
      do_read(64'h800, 64'h55AA_55AA_55AA_55AA, RESP_OKAY);

      repeat (2) step();
      chk("leftover_ar", exp_ar.size(), 0);
      chk("leftover_aw", exp_aw.size(), 0);
      chk("leftover_w", exp_w.size(), 0);
      chk("leftover_resp", exp_resp.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/peripheral_mpram_axi4_initiator.md
# peripheral_mpram_axi4_initiator

AXI4 master-side bridge: accepts single-word requests on the MPRAM memory-port interface (req/we/addr/be/data) and issues them as single-beat AXI4 read or write transactions, returning read data or write completion. Sits between a core/DMA-side memory port and an AXI4 interconnect that fronts an MPRAM AXI4 slave. One transaction is outstanding at a time.

## Interface
- AXI_ID_WIDTH, 10, ID width.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; power of two, ≥ 8.
- AXI_STRB_WIDTH, 8, equals AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 10, user width.
- AXI_ID, 0, constant ID driven on AW/AR.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i, we_i  in  1  request valid; 1 = write.
- addr_i  in  AXI_ADDR_WIDTH  byte address, passed unmodified.
- be_i  in  AXI_STRB_WIDTH  byte enables (writes).
- data_i  in  AXI_DATA_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  one-cycle completion pulse (read data or write ack).
- data_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o.
- err_o  out  1  response was SLVERR/DECERR, valid with rvalid_o.
- axi_aw_{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out; axi_aw_ready  in.
- axi_w_{data,strb,last,user,valid}  out; axi_w_ready  in.
- axi_b_{id,resp,user,valid}  in; axi_b_ready  out.
- axi_ar_{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out; axi_ar_ready  in.
- axi_r_{id,data,resp,last,user,valid}  in; axi_r_ready  out.

## Operation
- States: IDLE, AR, R, AW_W, B.
- IDLE: gnt_o = req_i (combinational). On gnt, register addr/be/data/we; go AR if !we_i else AW_W (clearing aw_done, w_done).
- AR: axi_ar_valid=1 from registered addr; on axi_ar_ready → R.
- R: axi_r_ready=1; on axi_r_valid: rvalid_o=1, data_o=axi_r_data, err_o=axi_r_resp[1] (combinational pass-through) → IDLE.
- AW_W: axi_aw_valid=!aw_done, axi_w_valid=!w_done, issued together. Each handshake sets its done flag. Leave to B when both handshakes complete, whether in the same cycle or different cycles.
- B: axi_b_ready=1; on axi_b_valid: rvalid_o=1, err_o=axi_b_resp[1], data_o unchanged → IDLE.
- Fixed fields: len=0, size=$clog2(AXI_STRB_WIDTH), burst=INCR (2'b01), w_last=1, lock/cache/prot/qos/region/user=0, id=AXI_ID.
- Valid outputs and payloads stay stable until their handshake completes (AXI rule). No valid depends on a ready.
- axi_r_last, axi_r_id, axi_b_id and user inputs are ignored.

## Timing
- Reset: state IDLE; all AXI valids, axi_b_ready, axi_r_ready, gnt_o, rvalid_o, err_o = 0; data_o = 0; registered payloads = 0.
- The earliest gnt_o is in the first cycle after reset deasserts when req_i=1.
- Minimum read latency, with ready/valid returned immediately: gnt at cycle 0, AR handshake at cycle 1, R data and rvalid_o at cycle 2.
- Minimum write latency: gnt at cycle 0, AW+W handshake at cycle 1, B and rvalid_o at cycle 2.
- gnt_o=0 in every state except IDLE. req_i held high is granted in the cycle the block returns to IDLE, so back-to-back throughput is one transaction per 3 cycles.
- Reset mid-transaction abandons the transaction immediately and drops the valids. This is allowed only under a system-wide reset.

## Structure
- Shared package peripheral_mpram_axi4_pkg holds: axi_burst_t (FIXED/INCR/WRAP), response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), and the state enum.
- No sub-module: a single FSM with payload registers.

## Test plan
- Read, ready/valid at zero wait: req_i=1, we_i=0, addr_i=0x100 → ar_addr=0x100, len=0, size=3 at cycle 1; r_data=0xDEADBEEF at cycle 2 → rvalid_o=1, data_o=0xDEADBEEF, err_o=0.
- Write with AW ready at cycle 1 and W ready at cycle 4: data 0x1122334455667788, be=0x0F → w_valid held with stable data until cycle 4, b_ready=1 from cycle 5; b_resp=OKAY → rvalid_o pulse.
- Write with W accepted before AW (w_ready at cycle 1, aw_ready at cycle 3) → w_valid drops at cycle 2, aw_valid held until 3, then B.
- Error response: r_resp=2'b10 → rvalid_o=1, err_o=1; b_resp=2'b11 → err_o=1.
- Back-to-back with req_i held: read then write → second gnt_o exactly in the cycle after the first rvalid_o, with no overlap of AXI valids.
- Reset asserted while in AR with ar_valid=1 → ar_valid=0 immediately; after release, state IDLE and gnt_o follows req_i.
